// File: rtl/gpio_dir_sequencer_if.sv
// Command channel into the GPIO direction sequencer. One atomic update is a
// {drive value, tri-state mask} pair that moves on a valid/ready handshake.
interface gpio_dir_sequencer_if #(
    parameter int WIDTH = 72
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_w;
    logic [WIDTH-1:0] cmd_s;

    modport master (
        output cmd_valid,
        output cmd_w,
        output cmd_s,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_w,
        input  cmd_s,
        output cmd_ready
    );
endinterface

// File: rtl/gpio_dir_sequencer.sv
// GPIO direction sequencer: owns the gpio_w / gpio_s buses feeding the pad
// tri-state buffers and applies {value, direction} updates break-before-make.
// Any pin whose direction changes sits high-Z for DEAD_CYCLES clocks before
// the new drive values appear. Also synchronises the pad read-back bus.
// reset_n asserts asynchronously; its release is expected to be aligned to
// clk by the board reset generator.
module gpio_dir_sequencer #(
    parameter int WIDTH       = 72,
    parameter int DEAD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    gpio_dir_sequencer_if.slave  cmd,
    output logic [WIDTH-1:0]     gpio_w,
    output logic [WIDTH-1:0]     gpio_s,
    input  logic [WIDTH-1:0]     pad_r,
    output logic [WIDTH-1:0]     gpio_r,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     commit_cnt
);

    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DEAD = 1'b1
    } state_t;

    state_t             state_reg;
    logic [DEAD_W-1:0]  dead_cnt_reg;
    logic [WIDTH-1:0]   gpio_w_reg;
    logic [WIDTH-1:0]   gpio_s_reg;
    logic [WIDTH-1:0]   lat_w_reg;
    logic [WIDTH-1:0]   lat_s_reg;
    logic               ready_reg;
    logic               done_reg;
    logic [CNT_W-1:0]   commit_cnt_reg;
    logic               accept;

    // A command is taken only while the registered ready is high.
    assign accept = cmd.cmd_valid & ready_reg;

    // Sequencer FSM: immediate commit when no pin changes direction, otherwise
    // tri-state the changing pins and hold for the dead-time before commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            dead_cnt_reg   <= '0;
            gpio_w_reg     <= '0;
            gpio_s_reg     <= '1;
            lat_w_reg      <= '0;
            lat_s_reg      <= '0;
            ready_reg      <= 1'b1;
            done_reg       <= 1'b0;
            commit_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if ((gpio_s_reg ^ cmd.cmd_s) == '0) begin
                            gpio_w_reg     <= cmd.cmd_w;
                            gpio_s_reg     <= cmd.cmd_s;
                            done_reg       <= 1'b1;
                            commit_cnt_reg <= commit_cnt_reg + CNT_W'(1);
                        end else begin
                            // Pins driven before and after keep their old value;
                            // every other pin that is or becomes an input is high-Z.
                            lat_w_reg    <= cmd.cmd_w;
                            lat_s_reg    <= cmd.cmd_s;
                            gpio_s_reg   <= gpio_s_reg | cmd.cmd_s;
                            dead_cnt_reg <= DEAD_W'(DEAD_CYCLES - 1);
                            state_reg    <= DEAD;
                            ready_reg    <= 1'b0;
                        end
                    end
                end
                DEAD: begin
                    if (dead_cnt_reg != '0) begin
                        dead_cnt_reg <= dead_cnt_reg - DEAD_W'(1);
                    end else begin
                        gpio_w_reg     <= lat_w_reg;
                        gpio_s_reg     <= lat_s_reg;
                        done_reg       <= 1'b1;
                        commit_cnt_reg <= commit_cnt_reg + CNT_W'(1);
                        state_reg      <= IDLE;
                        ready_reg      <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser per pin for the asynchronous pad read-back.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Ungated double-flop; independent of the sequencer state.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= pad_r[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign gpio_r[gi] = sync_reg;
        end
    endgenerate

    assign cmd.cmd_ready = ready_reg;
    assign busy          = ~ready_reg;
    assign done          = done_reg;
    assign gpio_w        = gpio_w_reg;
    assign gpio_s        = gpio_s_reg;
    assign commit_cnt    = commit_cnt_reg;

endmodule

// File: tb/tb_gpio_dir_sequencer.sv
// Bench for gpio_dir_sequencer: directed scenarios followed by random traffic,
// checked against a cycle-count reference model and a commit scoreboard.
module tb_gpio_dir_sequencer;

    localparam int WIDTH       = 8;
    localparam int DEAD_CYCLES = 4;
    localparam int CNT_W       = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] pad_r = '0;
    logic [WIDTH-1:0] gpio_w;
    logic [WIDTH-1:0] gpio_s;
    logic [WIDTH-1:0] gpio_r;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] commit_cnt;

    gpio_dir_sequencer_if #(.WIDTH(WIDTH)) cmd_if ();

    gpio_dir_sequencer #(
        .WIDTH       (WIDTH),
        .DEAD_CYCLES (DEAD_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (cmd_if.slave),
        .gpio_w     (gpio_w),
        .gpio_s     (gpio_s),
        .pad_r      (pad_r),
        .gpio_r     (gpio_r),
        .busy       (busy),
        .done       (done),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pin state as seen by the pads, plus one pending command
    // that becomes visible DEAD_CYCLES edges after it was accepted.
    logic [WIDTH-1:0] m_w = '0;
    logic [WIDTH-1:0] m_s = '1;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_done = 1'b0;
    logic             m_acc = 1'b0;
    logic             pend_valid = 1'b0;
    logic [WIDTH-1:0] pend_w = '0;
    logic [WIDTH-1:0] pend_s = '0;
    int               pend_due = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] pad_hist [2];

    typedef struct packed {
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] s;
        logic [CNT_W-1:0] cnt;
    } commit_t;
    commit_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w        = '0;
        m_s        = '1;
        m_cnt      = '0;
        m_done     = 1'b0;
        m_acc      = 1'b0;
        pend_valid = 1'b0;
        pad_hist[0] = '0;
        pad_hist[1] = '0;
        exp_q.delete();
    endtask

    task automatic model_commit(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] s);
        commit_t c;
        m_w    = w;
        m_s    = s;
        m_cnt  = m_cnt + 1'b1;
        m_done = 1'b1;
        c.w = w; c.s = s; c.cnt = m_cnt;
        exp_q.push_back(c);
    endtask

    // One rising edge worth of model evolution, using the inputs held since the
    // preceding falling edge.
    task automatic model_step();
        if (!reset_n) return;
        cyc++;
        m_done = 1'b0;
        m_acc  = 1'b0;
        pad_hist[1] = pad_hist[0];
        pad_hist[0] = pad_r;
        if (pend_valid) begin
            if (cyc == pend_due) begin
                model_commit(pend_w, pend_s);
                pend_valid = 1'b0;
            end
        end else if (cmd_if.cmd_valid) begin
            m_acc = 1'b1;
            if (m_s == cmd_if.cmd_s) begin
                model_commit(cmd_if.cmd_w, cmd_if.cmd_s);
            end else begin
                m_s        = m_s | cmd_if.cmd_s;
                pend_w     = cmd_if.cmd_w;
                pend_s     = cmd_if.cmd_s;
                pend_due   = cyc + DEAD_CYCLES;
                pend_valid = 1'b1;
            end
        end
    endtask

    // Drive one clock: inputs on the falling edge, model on the rising edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] s);
        @(negedge clk);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_w     = w;
        cmd_if.cmd_s     = s;
        pad_r            = WIDTH'($urandom);
        @(posedge clk);
        model_step();
    endtask

    // Present a command until the model says it was taken.
    task automatic send(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] s);
        int guard = 0;
        do begin
            cycle(1'b1, w, s);
            guard++;
        end while (!m_acc && guard < 50);
        check("send_accept_timeout", {31'd0, m_acc}, 32'd1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (pend_valid && guard < 50) begin
            cycle(1'b0, '0, '0);
            guard++;
        end
        check("idle_timeout", {31'd0, pend_valid}, 32'd0);
    endtask

    // Monitor: every falling edge compare outputs with the model, and on each
    // done pulse pop the scoreboard entry for that commit.
    initial begin
        commit_t c;
        pad_hist[0] = '0;
        pad_hist[1] = '0;
        forever begin
            @(negedge clk);
            check("gpio_w", gpio_w, m_w);
            check("gpio_s", gpio_s, m_s);
            check("cmd_ready", cmd_if.cmd_ready, !pend_valid);
            check("busy", busy, pend_valid);
            check("done", done, m_done);
            check("commit_cnt", commit_cnt, m_cnt);
            check("gpio_r", gpio_r, pad_hist[1]);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    c = exp_q.pop_front();
                    check("sb_w", gpio_w, c.w);
                    check("sb_s", gpio_s, c.s);
                    check("sb_cnt", commit_cnt, c.cnt);
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] rs;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_w     = '0;
        cmd_if.cmd_s     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        model_step();

        // 1: reset state
        #1;
        check("t1_gpio_s", gpio_s, 8'hFF);
        check("t1_gpio_w", gpio_w, 8'h00);
        check("t1_ready", cmd_if.cmd_ready, 1'b1);
        check("t1_cnt", commit_cnt, 4'd0);

        // 2: no direction change commits on the accept edge
        send(8'h5A, 8'hFF);
        #1;
        check("t2_gpio_w", gpio_w, 8'h5A);
        check("t2_ready", cmd_if.cmd_ready, 1'b1);
        check("t2_done", done, 1'b1);
        check("t2_cnt", commit_cnt, 4'd1);
        $display("txn t2 w=%h s=%h cnt=%0d", gpio_w, gpio_s, commit_cnt);

        // 3: direction change holds high-Z for the dead time
        send(8'hA5, 8'h0F);
        #1;
        check("t3_dead_s", gpio_s, 8'hFF);
        check("t3_ready", cmd_if.cmd_ready, 1'b0);
        wait_idle();
        #1;
        check("t3_gpio_s", gpio_s, 8'h0F);
        check("t3_gpio_w", gpio_w, 8'hA5);
        $display("txn t3 w=%h s=%h cnt=%0d", gpio_w, gpio_s, commit_cnt);

        // 4: partial direction change; pins 0/1 keep driving through dead time
        send(8'h05, 8'h0F);
        send(8'h14, 8'h3C);
        #1;
        check("t4_dead_s", gpio_s, 8'h3F);
        check("t4_dead_w", gpio_w, 8'h05);

        // 5: valid held with other data during dead time is ignored
        begin
            int guard = 0;
            while (pend_valid && guard < 50) begin
                cycle(1'b1, 8'hFF, 8'h00);
                guard++;
            end
        end
        #1;
        check("t4_gpio_s", gpio_s, 8'h3C);
        check("t4_gpio_w", gpio_w, 8'h14);
        $display("txn t4 w=%h s=%h cnt=%0d", gpio_w, gpio_s, commit_cnt);
        cycle(1'b1, 8'hFF, 8'h00);
        #1;
        check("t5_second_accept", cmd_if.cmd_ready, 1'b0);
        wait_idle();
        $display("txn t5 w=%h s=%h cnt=%0d", gpio_w, gpio_s, commit_cnt);

        // 6: reset two cycles into a dead time discards the pending command
        send(8'h00, 8'hFF);
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t6_gpio_s", gpio_s, 8'hFF);
        check("t6_gpio_w", gpio_w, 8'h00);
        check("t6_ready", cmd_if.cmd_ready, 1'b1);
        check("t6_cnt", commit_cnt, 4'd0);
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        model_step();
        repeat (8) cycle(1'b0, '0, '0);
        $display("txn t6 w=%h s=%h cnt=%0d", gpio_w, gpio_s, commit_cnt);

        // 17 commits wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) cycle(1'b1, WIDTH'($urandom), 8'hFF);
        #1;
        check("t5_wrap_cnt", commit_cnt, 4'd1);
        $display("txn wrap cnt=%0d", commit_cnt);

        // Random traffic; masks biased towards repeating the current direction
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 2) == 0) ? m_s : WIDTH'($urandom);
            cycle(($urandom_range(0, 3) != 0), WIDTH'($urandom), rs);
            if (m_acc) $display("txn rnd w=%h s=%h pend=%0d", cmd_if.cmd_w, cmd_if.cmd_s, pend_valid);
        end
        wait_idle();
        repeat (4) cycle(1'b0, '0, '0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
